// File: rtl/sd_timeout_unit_if.sv
// sd_timeout_unit_if: control/status bundle of the multi-channel timeout unit.
//
// Signalling: there is no valid/ready handshake on this bundle. start_i and
// stop_i are sampled on every rising clock edge; a one-cycle pulse acts once,
// a held level acts again on every edge it is high. pause_i is a level.
// exp_i is looked at only on an edge where start_i is high for that channel.
// All status outputs are valid every cycle. state_o exposes each channel's
// FSM state (2 bits per channel) for observation.
interface sd_timeout_unit_if #(
  parameter int NumChannels  = 2,
  parameter int CounterWidth = 28
);
  logic [NumChannels-1:0]              start_i;
  logic [NumChannels-1:0]              stop_i;
  logic [NumChannels-1:0]              pause_i;
  logic [NumChannels*4-1:0]            exp_i;
  logic [NumChannels-1:0]              running_o;
  logic [NumChannels-1:0]              expired_o;
  logic [NumChannels-1:0]              expired_pulse_o;
  logic [NumChannels*CounterWidth-1:0] cnt_o;
  logic [NumChannels*2-1:0]            state_o;

  // Host side: drives channel control, observes status.
  modport master (
    output start_i, stop_i, pause_i, exp_i,
    input  running_o, expired_o, expired_pulse_o, cnt_o, state_o
  );

  // Timeout unit side.
  modport slave (
    input  start_i, stop_i, pause_i, exp_i,
    output running_o, expired_o, expired_pulse_o, cnt_o, state_o
  );
endinterface

// File: rtl/sd_timeout_unit.sv
// sd_timeout_unit: NumChannels independent timeout channels sharing one
// prescaler. Each channel counts prescaler ticks from a start pulse until
// 2**min(exp+MinExp, MaxExp) ticks have elapsed, then sits in EXPIRED with a
// sticky flag and a one-cycle entry pulse until restarted or stopped.
//
// Optional build macro: SDHCI_TIMEOUT_CNT_EN -- when defined, cnt_o carries
// each channel's live counter; when undefined, cnt_o is tied to zero. Channel
// behaviour is identical in both builds.
module sd_timeout_unit #(
  parameter int NumChannels  = 2,
  parameter int ClockDiv     = 1,
  parameter int MinExp       = 13,
  parameter int MaxExp       = 27,
  parameter int CounterWidth = MaxExp + 1
) (
  input logic              clk_i,
  input logic              rst_ni,
  sd_timeout_unit_if.slave bus
);

  // Wide enough that exp_i (max 15) + MinExp never overflows.
  localparam int ExpW = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (CounterWidth < MaxExp + 1) begin : g_chk_cnt_width
    $error("sd_timeout_unit: CounterWidth must be >= MaxExp+1");
  end
  if (NumChannels < 1 || NumChannels > 8) begin : g_chk_channels
    $error("sd_timeout_unit: NumChannels must be in 1..8");
  end
  if (ClockDiv < 1) begin : g_chk_div
    $error("sd_timeout_unit: ClockDiv must be >= 1");
  end
  if (MinExp < 0 || MaxExp < 0 || MinExp + 15 > 63 || MaxExp > 63) begin : g_chk_exp
    $error("sd_timeout_unit: MinExp/MaxExp out of range");
  end

  // ---------------------------------------------------------------------------
  // Shared prescaler: tick is high on the cycle where the prescaler is zero.
  // ---------------------------------------------------------------------------
  logic tick;

  if (ClockDiv > 1) begin : g_presc
    localparam int PrescW = $clog2(ClockDiv);
    logic [PrescW-1:0] presc_q;

    // Free-running 0..ClockDiv-1 counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        presc_q <= '0;
      end else if (presc_q == PrescW'(ClockDiv - 1)) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + PrescW'(1);
      end
    end

    assign tick = (presc_q == '0);
  end else begin : g_no_presc
    assign tick = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Per-channel state
  // ---------------------------------------------------------------------------
  state_e                  state_q [NumChannels];
  state_e                  state_d [NumChannels];
  logic [CounterWidth-1:0] cnt_q   [NumChannels];
  logic [CounterWidth-1:0] cnt_d   [NumChannels];
  logic [CounterWidth-1:0] cnt_inc [NumChannels];
  logic [CounterWidth-1:0] thresh  [NumChannels];
  logic [ExpW-1:0]         exp_q   [NumChannels];
  logic [ExpW-1:0]         exp_d   [NumChannels];
  logic [ExpW-1:0]         exp_new [NumChannels];
  logic [NumChannels-1:0]  pulse_q;
  logic [NumChannels-1:0]  pulse_d;

  // Per-channel arithmetic: clamped exponent for a start, current threshold
  // from the latched exponent, and the incremented count. exp_q never exceeds
  // MaxExp, so the shifted one always fits in CounterWidth bits.
  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      exp_new[c] = {2'b00, bus.exp_i[c*4 +: 4]} + ExpW'(MinExp);
      if (exp_new[c] > ExpW'(MaxExp)) begin
        exp_new[c] = ExpW'(MaxExp);
      end
      thresh[c]  = CounterWidth'(1) << exp_q[c];
      cnt_inc[c] = cnt_q[c] + CounterWidth'(1);
    end
  end

  // State register: FSM state, counter, latched exponent and entry pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumChannels; c++) begin
        state_q[c] <= ST_IDLE;
        cnt_q[c]   <= '0;
        exp_q[c]   <= '0;
      end
      pulse_q <= '0;
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        exp_q[c]   <= exp_d[c];
      end
      pulse_q <= pulse_d;
    end
  end

  // Next-state logic. Priority per channel: start > stop > pause/tick.
  // The counter stops at the threshold on the expiring tick, so it never wraps.
  always_comb begin
    pulse_d = '0;
    for (int c = 0; c < NumChannels; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      exp_d[c]   = exp_q[c];
      if (bus.start_i[c]) begin
        state_d[c] = ST_RUN;
        cnt_d[c]   = '0;
        exp_d[c]   = exp_new[c];
      end else if (bus.stop_i[c]) begin
        state_d[c] = ST_IDLE;
        cnt_d[c]   = '0;
      end else begin
        unique case (state_q[c])
          ST_RUN: begin
            if (bus.pause_i[c]) begin
              state_d[c] = ST_PAUSED;
            end else if (tick) begin
              cnt_d[c] = cnt_inc[c];
              if (cnt_inc[c] == thresh[c]) begin
                state_d[c] = ST_EXPIRED;
              end
            end
          end
          ST_PAUSED: begin
            // The resume cycle itself does not count, even on a tick.
            if (!bus.pause_i[c]) begin
              state_d[c] = ST_RUN;
            end
          end
          default: begin
            // IDLE and EXPIRED hold; pause_i is ignored here.
          end
        endcase
      end
      pulse_d[c] = (state_d[c] == ST_EXPIRED) && (state_q[c] != ST_EXPIRED);
    end
  end

  // Output decode from registered state.
  always_comb begin
    bus.running_o       = '0;
    bus.expired_o       = '0;
    bus.expired_pulse_o = pulse_q;
    bus.cnt_o           = '0;
    bus.state_o         = '0;
    for (int c = 0; c < NumChannels; c++) begin
      bus.running_o[c]      = (state_q[c] == ST_RUN) || (state_q[c] == ST_PAUSED);
      bus.expired_o[c]      = (state_q[c] == ST_EXPIRED);
      bus.state_o[c*2 +: 2] = state_q[c];
`ifdef SDHCI_TIMEOUT_CNT_EN
      bus.cnt_o[c*CounterWidth +: CounterWidth] = cnt_q[c];
`endif
    end
  end

endmodule

// File: tb/tb_sd_timeout_unit.sv
// tb_sd_timeout_unit: two instances of the timeout unit.
//   dut_a: ClockDiv=1, MinExp=13, MaxExp=15 -- directed timing scenarios.
//   dut_b: ClockDiv=4, MinExp=2,  MaxExp=6  -- prescaler scenario and random
//          traffic checked against a behavioural channel model.
module tb_sd_timeout_unit;

  localparam int NCH  = 2;
  localparam int CW_A = 16;
  localparam int CW_B = 7;

`ifdef SDHCI_TIMEOUT_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUTs
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  sd_timeout_unit_if #(.NumChannels(NCH), .CounterWidth(CW_A)) bus_a ();
  sd_timeout_unit_if #(.NumChannels(NCH), .CounterWidth(CW_B)) bus_b ();

  sd_timeout_unit #(
    .NumChannels(NCH), .ClockDiv(1), .MinExp(13), .MaxExp(15), .CounterWidth(CW_A)
  ) dut_a (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_a)
  );

  sd_timeout_unit #(
    .NumChannels(NCH), .ClockDiv(4), .MinExp(2), .MaxExp(6), .CounterWidth(CW_B)
  ) dut_b (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_b)
  );

  // ---------------------------------------------------------------------------
  // Reference model for dut_b: each channel is a timer session (active,
  // paused, done) with a tick count and a threshold in ticks. Ticks arrive on
  // every 4th clock edge counted from reset release, first edge included.
  // ---------------------------------------------------------------------------
  int unsigned edge_b = 0;
  bit m_run   [NCH];
  bit m_pau   [NCH];
  bit m_done  [NCH];
  bit m_pulse [NCH];
  int m_cnt   [NCH];
  int m_thr   [NCH];
  bit m_tick;
  int m_e;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        edge_b = 0;
        for (int c = 0; c < NCH; c++) begin
          m_run[c] = 0; m_pau[c] = 0; m_done[c] = 0; m_pulse[c] = 0;
          m_cnt[c] = 0; m_thr[c] = 1;
        end
      end else begin
        m_tick = (edge_b % 4) == 0;
        edge_b++;
        for (int c = 0; c < NCH; c++) begin
          m_pulse[c] = 0;
          if (bus_b.start_i[c]) begin
            m_e = int'(bus_b.exp_i[c*4 +: 4]) + 2;
            if (m_e > 6) m_e = 6;
            m_thr[c] = 1 << m_e;
            m_run[c] = 1; m_pau[c] = 0; m_done[c] = 0; m_cnt[c] = 0;
          end else if (bus_b.stop_i[c]) begin
            m_run[c] = 0; m_pau[c] = 0; m_done[c] = 0; m_cnt[c] = 0;
          end else if (m_run[c] && m_pau[c]) begin
            if (!bus_b.pause_i[c]) m_pau[c] = 0;
          end else if (m_run[c]) begin
            if (bus_b.pause_i[c]) begin
              m_pau[c] = 1;
            end else if (m_tick) begin
              m_cnt[c]++;
              if (m_cnt[c] == m_thr[c]) begin
                m_run[c] = 0; m_done[c] = 1; m_pulse[c] = 1;
              end
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called right after a falling edge; return after the next one)
  // ---------------------------------------------------------------------------
  task automatic a_start(input int ch, input logic [3:0] e);
    bus_a.start_i[ch]        = 1'b1;
    bus_a.exp_i[ch*4 +: 4]   = e;
    @(negedge clk);
    bus_a.start_i[ch]        = 1'b0;
  endtask

  task automatic a_stop(input int ch);
    bus_a.stop_i[ch] = 1'b1;
    @(negedge clk);
    bus_a.stop_i[ch] = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #2;
    total++;
    if ({bus_a.running_o, bus_a.expired_o, bus_a.expired_pulse_o} !== '0 || bus_a.cnt_o !== '0) begin
      bad++; $display("FAIL reset_a_in got run=%b exp=%b pls=%b cnt=%h want all 0",
                      bus_a.running_o, bus_a.expired_o, bus_a.expired_pulse_o, bus_a.cnt_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({bus_a.running_o, bus_a.expired_o, bus_a.expired_pulse_o} !== '0 || bus_a.cnt_o !== '0) begin
      bad++; $display("FAIL reset_a_out got run=%b exp=%b pls=%b cnt=%h want all 0",
                      bus_a.running_o, bus_a.expired_o, bus_a.expired_pulse_o, bus_a.cnt_o);
    end
    total++;
    if ({bus_b.running_o, bus_b.expired_o, bus_b.expired_pulse_o} !== '0 || bus_b.cnt_o !== '0) begin
      bad++; $display("FAIL reset_b_out got run=%b exp=%b pls=%b cnt=%h want all 0",
                      bus_b.running_o, bus_b.expired_o, bus_b.expired_pulse_o, bus_b.cnt_o);
    end
  endtask

  // exp=0 -> 2**13 ticks: expired_o rises after edge 8192, pulse for one cycle.
  task automatic test_basic_expiry();
    a_start(0, 4'd0);
    bus_a.exp_i[3:0] = 4'd9;  // changing exp outside a start must not matter
    for (int k = 1; k <= 8195; k++) begin
      @(negedge clk);
      total++;
      if (bus_a.expired_o[0] !== (k >= 8192)) begin
        bad++; $display("FAIL basic_expired edge=%0d got=%b want=%b", k, bus_a.expired_o[0], k >= 8192);
      end
      total++;
      if (bus_a.expired_pulse_o[0] !== (k == 8192)) begin
        bad++; $display("FAIL basic_pulse edge=%0d got=%b want=%b", k, bus_a.expired_pulse_o[0], k == 8192);
      end
      total++;
      if (bus_a.running_o[0] !== (k < 8192)) begin
        bad++; $display("FAIL basic_running edge=%0d got=%b want=%b", k, bus_a.running_o[0], k < 8192);
      end
      total++;
      if ({bus_a.running_o[1], bus_a.expired_o[1], bus_a.expired_pulse_o[1]} !== 3'b000) begin
        bad++; $display("FAIL basic_ch1_idle edge=%0d got=%b want=000", k,
                        {bus_a.running_o[1], bus_a.expired_o[1], bus_a.expired_pulse_o[1]});
      end
    end
  endtask

  // pause_i sampled high on edges 1000..1099: those 100 edges do not count, and
  // neither does edge 1100 (PAUSED -> RUN). Expiry lands on edge 8192+101.
  task automatic test_pause();
    int exp_edge;
    exp_edge = 8192 + 100 + 1;
    a_start(0, 4'd0);
    for (int k = 1; k <= exp_edge + 3; k++) begin
      @(negedge clk);
      total++;
      if (bus_a.expired_o[0] !== (k >= exp_edge)) begin
        bad++; $display("FAIL pause_expired edge=%0d got=%b want=%b", k, bus_a.expired_o[0], k >= exp_edge);
      end
      total++;
      if (bus_a.running_o[0] !== (k < exp_edge)) begin
        bad++; $display("FAIL pause_running edge=%0d got=%b want=%b", k, bus_a.running_o[0], k < exp_edge);
      end
      bus_a.pause_i[0] = (k + 1 >= 1000) && (k + 1 <= 1099);
    end
  endtask

  // Stop at edge 5000: channel idles, no flag or pulse through the would-be expiry.
  task automatic test_stop();
    a_start(0, 4'd0);
    for (int k = 1; k <= 8200; k++) begin
      @(negedge clk);
      total++;
      if (bus_a.running_o[0] !== (k < 5000)) begin
        bad++; $display("FAIL stop_running edge=%0d got=%b want=%b", k, bus_a.running_o[0], k < 5000);
      end
      total++;
      if ({bus_a.expired_o[0], bus_a.expired_pulse_o[0]} !== 2'b00) begin
        bad++; $display("FAIL stop_no_expiry edge=%0d got=%b want=00", k,
                        {bus_a.expired_o[0], bus_a.expired_pulse_o[0]});
      end
      bus_a.stop_i[0] = (k + 1 == 5000);
    end
  endtask

  // ch0 exp=2 (2**15) and ch1 exp=15 (clamped to 2**15): both expire together.
  task automatic test_clamp_simultaneous();
    bus_a.start_i = 2'b11;
    bus_a.exp_i   = {4'd15, 4'd2};
    @(negedge clk);
    bus_a.start_i = 2'b00;
    for (int k = 1; k <= 32770; k++) begin
      @(negedge clk);
      total++;
      if (bus_a.expired_o !== {2{k >= 32768}}) begin
        bad++; $display("FAIL clamp_expired edge=%0d got=%b want=%b", k, bus_a.expired_o, {2{k >= 32768}});
      end
      total++;
      if (bus_a.expired_pulse_o !== {2{k == 32768}}) begin
        bad++; $display("FAIL clamp_pulse edge=%0d got=%b want=%b", k, bus_a.expired_pulse_o, {2{k == 32768}});
      end
    end
  endtask

  // Both channels are EXPIRED on entry.
  task automatic test_restart_expired();
    bus_a.pause_i = 2'b11;
    repeat (3) @(negedge clk);
    bus_a.pause_i = 2'b00;
    total++;
    if (bus_a.expired_o !== 2'b11 || bus_a.running_o !== 2'b00) begin
      bad++; $display("FAIL pause_in_expired got exp=%b run=%b want exp=11 run=00", bus_a.expired_o, bus_a.running_o);
    end
    bus_a.start_i[0] = 1'b1;
    bus_a.stop_i[0]  = 1'b1;
    bus_a.exp_i[3:0] = 4'd0;
    @(negedge clk);
    bus_a.start_i[0] = 1'b0;
    bus_a.stop_i[0]  = 1'b0;
    total++;
    if ({bus_a.running_o[0], bus_a.expired_o[0], bus_a.expired_pulse_o[0]} !== 3'b100) begin
      bad++; $display("FAIL restart_ch0 got run/exp/pls=%b want=100",
                      {bus_a.running_o[0], bus_a.expired_o[0], bus_a.expired_pulse_o[0]});
    end
    total++;
    if (bus_a.expired_o[1] !== 1'b1) begin
      bad++; $display("FAIL restart_ch1_untouched got=%b want=1", bus_a.expired_o[1]);
    end
    a_stop(1);
    total++;
    if ({bus_a.running_o[1], bus_a.expired_o[1]} !== 2'b00) begin
      bad++; $display("FAIL stop_expired_ch1 got run/exp=%b want=00", {bus_a.running_o[1], bus_a.expired_o[1]});
    end
    bus_a.pause_i[1] = 1'b1;
    repeat (2) @(negedge clk);
    bus_a.pause_i[1] = 1'b0;
    total++;
    if (bus_a.running_o[1] !== 1'b0) begin
      bad++; $display("FAIL pause_in_idle got run=%b want=0", bus_a.running_o[1]);
    end
    a_stop(0);
    total++;
    if (bus_a.running_o[0] !== 1'b0) begin
      bad++; $display("FAIL stop_ch0 got run=%b want=0", bus_a.running_o[0]);
    end
  endtask

  // Counter readout: n edges after start the count is n (zero if readout is off).
  task automatic test_cnt();
    int n;
    n = $urandom_range(50, 300);
    a_start(0, 4'd0);
    repeat (n) @(negedge clk);
    total++;
    if (bus_a.cnt_o[CW_A-1:0] !== (CntEn ? CW_A'(n) : '0)) begin
      bad++; $display("FAIL cnt_after_n n=%0d got=%0d want=%0d", n, bus_a.cnt_o[CW_A-1:0], CntEn ? n : 0);
    end
    bus_a.pause_i[0] = 1'b1;
    repeat (5) @(negedge clk);
    bus_a.pause_i[0] = 1'b0;
    total++;
    if (bus_a.cnt_o[CW_A-1:0] !== (CntEn ? CW_A'(n) : '0) || bus_a.running_o[0] !== 1'b1) begin
      bad++; $display("FAIL cnt_paused_hold got cnt=%0d run=%b want cnt=%0d run=1",
                      bus_a.cnt_o[CW_A-1:0], bus_a.running_o[0], CntEn ? n : 0);
    end
    a_stop(0);
    total++;
    if (bus_a.cnt_o !== '0) begin
      bad++; $display("FAIL cnt_after_stop got=%h want=0", bus_a.cnt_o);
    end
  endtask

  // ClockDiv=4, threshold 4 ticks: flag rises 13..16 edges after start.
  task automatic test_prescaler();
    int first;
    first = -1;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    bus_b.start_i[0]   = 1'b1;
    bus_b.exp_i[3:0]   = 4'd0;
    @(negedge clk);
    bus_b.start_i[0]   = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (first < 0 && bus_b.expired_o[0] === 1'b1) first = k;
    end
    total++;
    if (first < 13 || first > 16) begin
      bad++; $display("FAIL presc_latency got=%0d want=13..16 (-1 = never)", first);
    end
    total++;
    if (bus_b.expired_o[0] !== m_done[0]) begin
      bad++; $display("FAIL presc_model got=%b want=%b", bus_b.expired_o[0], m_done[0]);
    end
    bus_b.stop_i[0] = 1'b1;
    @(negedge clk);
    bus_b.stop_i[0] = 1'b0;
  endtask

  // Random start/stop/pause/exp traffic on dut_b against the model.
  task automatic test_random();
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        total++;
        if (bus_b.running_o[c] !== m_run[c]) begin
          bad++; $display("FAIL rand_running ch%0d cyc=%0d got=%b want=%b", c, i, bus_b.running_o[c], m_run[c]);
        end
        total++;
        if (bus_b.expired_o[c] !== m_done[c]) begin
          bad++; $display("FAIL rand_expired ch%0d cyc=%0d got=%b want=%b", c, i, bus_b.expired_o[c], m_done[c]);
        end
        total++;
        if (bus_b.expired_pulse_o[c] !== m_pulse[c]) begin
          bad++; $display("FAIL rand_pulse ch%0d cyc=%0d got=%b want=%b", c, i, bus_b.expired_pulse_o[c], m_pulse[c]);
        end
        total++;
        if (bus_b.cnt_o[c*CW_B +: CW_B] !== (CntEn ? CW_B'(m_cnt[c]) : '0)) begin
          bad++; $display("FAIL rand_cnt ch%0d cyc=%0d got=%0d want=%0d", c, i,
                          bus_b.cnt_o[c*CW_B +: CW_B], CntEn ? m_cnt[c] : 0);
        end
      end
      for (int c = 0; c < NCH; c++) begin
        bus_b.start_i[c] = ($urandom_range(0, 399) == 0);
        bus_b.stop_i[c]  = ($urandom_range(0, 799) == 0);
        if ($urandom_range(0, 29) == 0) bus_b.pause_i[c] = ~bus_b.pause_i[c];
        bus_b.exp_i[c*4 +: 4] = 4'($urandom_range(0, 15));
      end
    end
    bus_b.start_i = '0;
    bus_b.stop_i  = '0;
    bus_b.pause_i = '0;
  endtask

  // Asynchronous reset mid-run clears everything without a clock edge.
  task automatic test_async_reset();
    a_start(0, 4'd0);
    bus_b.start_i = 2'b11;
    bus_b.exp_i   = 8'h44;
    @(negedge clk);
    bus_b.start_i = 2'b00;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus_a.running_o, bus_a.expired_o, bus_a.expired_pulse_o} !== '0 || bus_a.cnt_o !== '0) begin
      bad++; $display("FAIL async_rst_a got run=%b exp=%b pls=%b cnt=%h want all 0",
                      bus_a.running_o, bus_a.expired_o, bus_a.expired_pulse_o, bus_a.cnt_o);
    end
    total++;
    if ({bus_b.running_o, bus_b.expired_o, bus_b.expired_pulse_o} !== '0 || bus_b.cnt_o !== '0) begin
      bad++; $display("FAIL async_rst_b got run=%b exp=%b pls=%b cnt=%h want all 0",
                      bus_b.running_o, bus_b.expired_o, bus_b.expired_pulse_o, bus_b.cnt_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus_a.running_o, bus_a.expired_o, bus_a.expired_pulse_o, bus_b.running_o,
         bus_b.expired_o, bus_b.expired_pulse_o} !== '0) begin
      bad++; $display("FAIL async_rst_release got a=%b%b%b b=%b%b%b want all 0",
                      bus_a.running_o, bus_a.expired_o, bus_a.expired_pulse_o,
                      bus_b.running_o, bus_b.expired_o, bus_b.expired_pulse_o);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    bus_a.start_i = '0; bus_a.stop_i = '0; bus_a.pause_i = '0; bus_a.exp_i = '0;
    bus_b.start_i = '0; bus_b.stop_i = '0; bus_b.pause_i = '0; bus_b.exp_i = '0;
    #1 rst_n = 1'b0;
    test_reset();
    test_basic_expiry();
    test_pause();
    test_stop();
    test_clamp_simultaneous();
    test_restart_expired();
    test_cnt();
    test_prescaler();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog time=%0t limit reached", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
